// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_e;

  // Anode pattern with digit 0 (seconds ones) enabled
  localparam logic [3:0] AN_RESET = 4'b1110;

  localparam int unsigned DEB_DEPTH_DEFAULT = 3;

  // Active-low one-hot anode enable for a digit index
  function automatic logic [3:0] an_decode(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

  // Seconds field is digits 1:0, minutes field is digits 3:2
  function automatic logic digit_in_field(input logic [1:0] digit, input logic sel_sec);
    return sel_sec ? ~digit[1] : digit[1];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, tick-sampled shift-register debouncer
// and rising-edge press detector. A press is only accepted after the debounced
// level has been seen low at least once since reset, so a button held through
// reset does not fire.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_DEPTH = DEB_DEPTH_DEFAULT
) (
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_sample,
  input  logic i_raw,
  output logic o_press
);

  logic [1:0]           r_sync;
  logic [DEB_DEPTH-1:0] r_shift;
  logic [DEB_DEPTH-1:0] w_shift_nxt;
  logic                 w_all_one;
  logic                 w_all_zero;
  logic                 r_level;
  logic                 r_armed;
  logic                 r_press;

  assign w_shift_nxt = (r_shift << 1) | DEB_DEPTH'(r_sync[1]);
  assign w_all_one   = &w_shift_nxt;
  assign w_all_zero  = ~|w_shift_nxt;

  // Bring the raw asynchronous button into the clock domain
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

  // Sample on the scan tick; change level only when every sample agrees
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_shift <= '0;
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (i_sample) begin
        r_shift <= w_shift_nxt;
        if (w_all_one) begin
          r_level <= 1'b1;
          r_press <= ~r_level & r_armed;
        end else if (w_all_zero) begin
          r_level <= 1'b0;
          r_armed <= 1'b1;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: RUN/PAUSE/ADJ mode FSM issuing one-cycle counter
// commands, 4-digit display scan and adjust-field blink.
// Optional feature: define STOPWATCH_CTRL_BLINK_EN to build the blink logic;
// otherwise o_blank is tied low and i_tick_4hz is ignored.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_DEPTH = DEB_DEPTH_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic       i_tick_1hz,
  input  logic       i_tick_2hz,
  input  logic       i_tick_4hz,
  input  logic       i_tick_mux,
  input  logic       i_btn_pause,
  input  logic       i_btn_reset,
  input  logic       i_sw_adj,
  input  logic       i_sw_sel,
  output logic       o_cnt_en,
  output logic       o_cnt_clr,
  output logic       o_adj_sec,
  output logic       o_adj_min,
  output logic [3:0] o_an_n,
  output logic [1:0] o_digit_sel,
  output logic       o_blank
);

  logic [1:0] r_adj_sync;
  logic [1:0] r_sel_sync;
  logic       w_sw_adj;
  logic       w_sw_sel;
  logic       w_pause_press;
  logic       w_rst_press;

  state_e     r_state;
  state_e     w_state_d;
  state_e     r_resume;
  state_e     w_resume_d;

  logic       r_cnt_en;
  logic       r_cnt_clr;
  logic       r_adj_sec;
  logic       r_adj_min;
  logic       w_cnt_en_d;
  logic       w_cnt_clr_d;
  logic       w_adj_sec_d;
  logic       w_adj_min_d;

  logic [1:0] r_digit_sel;
  logic [1:0] w_digit_nxt;
  logic [3:0] r_an_n;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------

  // Two-flop synchronisers for the mode switches
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_adj_sync <= 2'b00;
      r_sel_sync <= 2'b00;
    end else begin
      r_adj_sync <= {r_adj_sync[0], i_sw_adj};
      r_sel_sync <= {r_sel_sync[0], i_sw_sel};
    end
  end

  assign w_sw_adj = r_adj_sync[1];
  assign w_sw_sel = r_sel_sync[1];

  btn_debounce #(
    .DEB_DEPTH (DEB_DEPTH)
  ) u_deb_pause (
    .i_clk    (i_clk),
    .i_arst   (i_arst),
    .i_sample (i_tick_mux),
    .i_raw    (i_btn_pause),
    .o_press  (w_pause_press)
  );

  btn_debounce #(
    .DEB_DEPTH (DEB_DEPTH)
  ) u_deb_reset (
    .i_clk    (i_clk),
    .i_arst   (i_arst),
    .i_sample (i_tick_mux),
    .i_raw    (i_btn_reset),
    .o_press  (w_rst_press)
  );

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------

  // State and resume-target registers
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state  <= ST_RUN;
      r_resume <= ST_RUN;
    end else begin
      r_state  <= w_state_d;
      r_resume <= w_resume_d;
    end
  end

  // Next state and command pulses; a clear press pre-empts everything else,
  // and a mode change swallows any tick arriving in the same cycle
  always_comb begin
    w_state_d   = r_state;
    w_resume_d  = r_resume;
    w_cnt_clr_d = w_rst_press;
    w_cnt_en_d  = 1'b0;
    w_adj_sec_d = 1'b0;
    w_adj_min_d = 1'b0;
    if (!w_rst_press) begin
      case (r_state)
        ST_RUN: begin
          if (w_sw_adj) begin
            w_state_d  = ST_ADJ;
            w_resume_d = ST_RUN;
          end else if (w_pause_press) begin
            w_state_d = ST_PAUSE;
          end else begin
            w_cnt_en_d = i_tick_1hz;
          end
        end
        ST_PAUSE: begin
          if (w_sw_adj) begin
            w_state_d  = ST_ADJ;
            w_resume_d = ST_PAUSE;
          end else if (w_pause_press) begin
            w_state_d = ST_RUN;
          end
        end
        ST_ADJ: begin
          if (!w_sw_adj) begin
            w_state_d = r_resume;
          end else if (i_tick_2hz) begin
            w_adj_sec_d = w_sw_sel;
            w_adj_min_d = ~w_sw_sel;
          end
        end
        default: begin
          w_state_d = ST_RUN;
        end
      endcase
    end
  end

  // Registered command pulses
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_adj_sec <= 1'b0;
      r_adj_min <= 1'b0;
    end else begin
      r_cnt_en  <= w_cnt_en_d;
      r_cnt_clr <= w_cnt_clr_d;
      r_adj_sec <= w_adj_sec_d;
      r_adj_min <= w_adj_min_d;
    end
  end

  assign o_cnt_en  = r_cnt_en;
  assign o_cnt_clr = r_cnt_clr;
  assign o_adj_sec = r_adj_sec;
  assign o_adj_min = r_adj_min;

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------

  assign w_digit_nxt = i_tick_mux ? r_digit_sel + 2'd1 : r_digit_sel;

  // Digit index and its anode pattern move together on the scan tick
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_digit_sel <= 2'd0;
      r_an_n      <= AN_RESET;
    end else begin
      r_digit_sel <= w_digit_nxt;
      r_an_n      <= an_decode(w_digit_nxt);
    end
  end

  assign o_digit_sel = r_digit_sel;
  assign o_an_n      = r_an_n;

  // ---------------------------------------------------------------------------
  // Adjust-field blink
  // ---------------------------------------------------------------------------

`ifdef STOPWATCH_CTRL_BLINK_EN
  logic r_blink_phase;
  logic w_blink_d;
  logic r_blank;

  // Phase runs only while staying in ADJ; zero on entry and everywhere else
  always_comb begin
    w_blink_d = 1'b0;
    if (w_state_d == ST_ADJ && r_state == ST_ADJ) begin
      w_blink_d = r_blink_phase ^ i_tick_4hz;
    end
  end

  // Blank is computed from next-state values so it lines up with the digit shown
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_blink_phase <= 1'b0;
      r_blank       <= 1'b0;
    end else begin
      r_blink_phase <= w_blink_d;
      r_blank       <= (w_state_d == ST_ADJ) & w_blink_d & digit_in_field(w_digit_nxt, w_sw_sel);
    end
  end

  assign o_blank = r_blank;
`else
  logic w_unused_tick_4hz;

  assign w_unused_tick_4hz = i_tick_4hz;
  assign o_blank           = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: expected command pulses are queued by
// the stimulus and matched by an independent monitor; scan, blank and state are
// checked against a small bench-side model.
module tb_stopwatch_ctrl;

  localparam int K_EN  = 0;
  localparam int K_CLR = 1;
  localparam int K_SEC = 2;
  localparam int K_MIN = 3;

  localparam int S_RUN   = 0;
  localparam int S_PAUSE = 1;
  localparam int S_ADJ   = 2;

  logic       clk = 1'b0;
  logic       arst;
  logic       tick_1hz, tick_2hz, tick_4hz, tick_mux;
  logic       btn_pause, btn_reset, sw_adj, sw_sel;
  logic       cnt_en, cnt_clr, adj_sec, adj_min, blank;
  logic [3:0] an_n;
  logic [1:0] digit_sel;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_press = 0;
  int   exp_digit = 0;
  bit   exp_blink = 1'b0;
  bit   exp_sel = 1'b0;
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  stopwatch_ctrl dut (
    .i_clk       (clk),
    .i_arst      (arst),
    .i_tick_1hz  (tick_1hz),
    .i_tick_2hz  (tick_2hz),
    .i_tick_4hz  (tick_4hz),
    .i_tick_mux  (tick_mux),
    .i_btn_pause (btn_pause),
    .i_btn_reset (btn_reset),
    .i_sw_adj    (sw_adj),
    .i_sw_sel    (sw_sel),
    .o_cnt_en    (cnt_en),
    .o_cnt_clr   (cnt_clr),
    .o_adj_sec   (adj_sec),
    .o_adj_min   (adj_min),
    .o_an_n      (an_n),
    .o_digit_sel (digit_sel),
    .o_blank     (blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  task automatic pop_check(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = q.pop_front();
      check("pulse_kind", kind, e.kind);
      check("pulse_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: every command pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (!arst) begin
      if (cnt_clr) pop_check(K_CLR);
      if (cnt_en)  pop_check(K_EN);
      if (adj_sec) pop_check(K_SEC);
      if (adj_min) pop_check(K_MIN);
    end
  end

  always @(negedge clk) begin
    if (dut.u_deb_pause.o_press) n_press++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mux_tick();
    tick_mux = 1'b1;
    step();
    tick_mux = 1'b0;
    exp_digit = (exp_digit + 1) % 4;
    check("an_n", int'(an_n), int'(an_tab[exp_digit]));
    check("digit_sel", int'(digit_sel), exp_digit);
    check("blank", int'(blank),
          int'(exp_blink && (exp_sel ? (exp_digit < 2) : (exp_digit >= 2))));
    step();
  endtask

  task automatic pulse_1hz(input bit expect_en);
    if (expect_en) q.push_back('{K_EN, cyc + 1});
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic pulse_2hz(input int kind);
    q.push_back('{kind, cyc + 1});
    tick_2hz = 1'b1;
    step();
    tick_2hz = 1'b0;
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    repeat (5) mux_tick();
    btn_pause = 1'b0;
    repeat (5) mux_tick();
  endtask

  initial begin
    arst = 1'b1;
    tick_1hz = 1'b0; tick_2hz = 1'b0; tick_4hz = 1'b0; tick_mux = 1'b0;
    btn_pause = 1'b0; btn_reset = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    repeat (3) step();

    // Reset values
    check("rst_cnt_en", int'(cnt_en), 0);
    check("rst_cnt_clr", int'(cnt_clr), 0);
    check("rst_adj_sec", int'(adj_sec), 0);
    check("rst_adj_min", int'(adj_min), 0);
    check("rst_an_n", int'(an_n), 'b1110);
    check("rst_digit_sel", int'(digit_sel), 0);
    check("rst_blank", int'(blank), 0);
    check("rst_state", int'(dut.r_state), S_RUN);
    arst = 1'b0;
    step();

    // Full scan rotation, then three counted seconds
    repeat (4) mux_tick();
    repeat (3) begin
      pulse_1hz(1'b1);
      step();
      step();
    end

    // Pause and resume
    press_pause();
    check("press_count_1", n_press, 1);
    check("state_paused", int'(dut.r_state), S_PAUSE);
    pulse_1hz(1'b0);
    step();
    step();
    press_pause();
    check("press_count_2", n_press, 2);
    check("state_resumed", int'(dut.r_state), S_RUN);
    pulse_1hz(1'b1);
    step();

    // Bounce 1,0,1 must not be accepted
    btn_pause = 1'b1; repeat (3) step(); mux_tick();
    btn_pause = 1'b0; repeat (3) step(); mux_tick();
    btn_pause = 1'b1; repeat (3) step(); mux_tick();
    btn_pause = 1'b0; repeat (3) step();
    repeat (3) mux_tick();
    check("press_count_bounce", n_press, 2);

    // PAUSE -> ADJ on minutes, two adjust ticks, blink, then seconds field
    press_pause();
    check("press_count_3", n_press, 3);
    sw_sel = 1'b0; exp_sel = 1'b0;
    repeat (3) step();
    sw_adj = 1'b1;
    repeat (4) step();
    check("state_adj", int'(dut.r_state), S_ADJ);
    check("resume_pause", int'(dut.r_resume), S_PAUSE);
    repeat (2) begin
      pulse_2hz(K_MIN);
      step();
    end
    pulse_1hz(1'b0);
    step();
    tick_4hz = 1'b1;
    step();
    tick_4hz = 1'b0;
`ifdef STOPWATCH_CTRL_BLINK_EN
    exp_blink = 1'b1;
`endif
    repeat (4) mux_tick();
    sw_sel = 1'b1;
    repeat (3) step();
    exp_sel = 1'b1;
    repeat (4) mux_tick();
    pulse_2hz(K_SEC);
    step();
    tick_4hz = 1'b1;
    step();
    tick_4hz = 1'b0;
    exp_blink = 1'b0;
    mux_tick();
    sw_adj = 1'b0;
    repeat (4) step();
    check("state_back_pause", int'(dut.r_state), S_PAUSE);
    check("blank_after_adj", int'(blank), 0);
    pulse_1hz(1'b0);
    step();

    // Back to RUN, then clear press coincident with a 1 Hz tick
    press_pause();
    check("press_count_4", n_press, 4);
    check("state_run_again", int'(dut.r_state), S_RUN);
    btn_reset = 1'b1;
    repeat (3) step();
    mux_tick();
    mux_tick();
    q.push_back('{K_CLR, cyc + 2});
    tick_mux = 1'b1;
    step();
    tick_mux = 1'b0;
    exp_digit = (exp_digit + 1) % 4;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    step();
    check("state_after_clr", int'(dut.r_state), S_RUN);
    btn_reset = 1'b0;
    repeat (4) mux_tick();

    // Asynchronous reset in ADJ with pause held
    sw_sel = 1'b0; exp_sel = 1'b0;
    sw_adj = 1'b1;
    repeat (4) step();
    check("state_adj_2", int'(dut.r_state), S_ADJ);
    btn_pause = 1'b1;
    repeat (3) step();
    #2 arst = 1'b1;
    sw_adj = 1'b0;
    #1;
    check("arst_state", int'(dut.r_state), S_RUN);
    check("arst_resume", int'(dut.r_resume), S_RUN);
    check("arst_an_n", int'(an_n), 'b1110);
    check("arst_digit_sel", int'(digit_sel), 0);
    check("arst_blank", int'(blank), 0);
    exp_digit = 0;
    exp_blink = 1'b0;
    step();
    arst = 1'b0;
    repeat (2) step();
    repeat (5) mux_tick();
    check("press_count_held", n_press, 4);
    check("state_held_run", int'(dut.r_state), S_RUN);
    btn_pause = 1'b0;
    repeat (4) mux_tick();
    press_pause();
    check("press_count_5", n_press, 5);
    check("state_final_pause", int'(dut.r_state), S_PAUSE);

    repeat (3) step();
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
